// File: rtl/uart_pkg.sv
// Shared encodings for the UART echo path: transform modes, TX FSM states
// and the default word width.
package uart_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_INV  = 2'd1,
        MODE_INC  = 2'd2,
        MODE_REV  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DONE = 2'd1,
        ST_GAP       = 2'd2,
        ST_CSUM      = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head word, registered occupancy and
// simultaneous push/pop (including push while full when a pop frees the slot).
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              push_ok_s, pop_ok_s;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == CNT_ZERO);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        pop_ok_s  = pop_i && !empty_o;
        push_ok_s = push_i && (!full_o || pop_ok_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_echo_fifo.sv
// Buffered UART echo: transforms received words, queues them and re-sends them
// through the TX handshake. Define ECHO_CSUM_EN to append an XOR checksum word after TERM_CHAR.
module uart_echo_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 0,
    parameter int CNT_W      = 16
`ifdef ECHO_CSUM_EN
    ,
    parameter logic [DATA_W-1:0] TERM_CHAR = DATA_W'(8'h0A)
`endif
) (
    input  logic                    MAX10_CLK1_50,
    input  logic                    reset,
    input  logic                    Rx_valid,
    input  logic [DATA_W-1:0]       rx_data,
    input  logic [1:0]              mode,
    input  logic                    o_Tx_Active,
    input  logic                    o_Tx_Done,
    output logic                    iTx_DV,
    output logic [DATA_W-1:0]       i_Tx_Byte,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow,
    output logic [CNT_W-1:0]        rx_cnt,
    output logic [CNT_W-1:0]        tx_cnt
);

    // The IDLE launch-decision cycle is itself the final idle clock, so GAP
    // holds for GAP_CYCLES-1 clocks (at least one).
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 1) ? (GAP_CYCLES - 2) : 0);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
    localparam logic [GAP_W-1:0]  GAP_ZERO  = GAP_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [DATA_W-1:0] DATA_ONE  = DATA_W'(1);
    localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(0);

    function automatic logic [DATA_W-1:0] xform(input logic [1:0] m, input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = d;
        case (mode_e'(m))
            MODE_PASS: r = d;
            MODE_INV:  r = ~d;
            MODE_INC:  r = d + DATA_ONE;
            MODE_REV: begin
                for (int i = 0; i < DATA_W; i++) begin
                    r[i] = d[DATA_W-1-i];
                end
            end
            default:   r = d;
        endcase
        return r;
    endfunction

    tx_state_e         state_q, state_d;
    logic              dv_q, dv_d;
    logic [DATA_W-1:0] byte_q, byte_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
    logic [DATA_W-1:0] head_s, xform_s;
`ifdef ECHO_CSUM_EN
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              csum_flight_q, csum_flight_d;
`endif

    assign xform_s = xform(mode, rx_data);

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (MAX10_CLK1_50),
        .reset_i (reset),
        .push_i  (fifo_push_s),
        .pop_i   (fifo_pop_s),
        .wdata_i (xform_s),
        .rdata_o (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count)
    );

    // Receive side: accept when space exists or a pop frees a slot this cycle.
    always_comb begin
        fifo_push_s = Rx_valid && (!fifo_full_s || fifo_pop_s);
        rx_cnt_d    = rx_cnt_q;
        overflow_d  = overflow_q;
        if (fifo_push_s) begin
            rx_cnt_d = rx_cnt_q + CNT_ONE;
        end else begin
            rx_cnt_d = rx_cnt_q;
        end
        if (Rx_valid && !fifo_push_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // TX FSM next-state and registered-output intent.
    always_comb begin
        state_d    = state_q;
        dv_d       = 1'b0;
        byte_d     = byte_q;
        tx_cnt_d   = tx_cnt_q;
        gap_d      = gap_q;
        fifo_pop_s = 1'b0;
`ifdef ECHO_CSUM_EN
        acc_d         = acc_q;
        csum_flight_d = csum_flight_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s && !o_Tx_Active) begin
                    fifo_pop_s = 1'b1;
                    dv_d       = 1'b1;
                    byte_d     = head_s;
                    state_d    = ST_WAIT_DONE;
`ifdef ECHO_CSUM_EN
                    acc_d         = acc_q ^ head_s;
                    csum_flight_d = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (o_Tx_Done) begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                    gap_d    = GAP_ZERO;
`ifdef ECHO_CSUM_EN
                    if (!csum_flight_q && (byte_q == TERM_CHAR)) begin
                        state_d = ST_CSUM;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    if (GAP_CYCLES > 0) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
`endif
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = GAP_ZERO;
                    state_d = ST_IDLE;
                end else begin
                    gap_d   = gap_q + GAP_ONE;
                    state_d = ST_GAP;
                end
            end
`ifdef ECHO_CSUM_EN
            ST_CSUM: begin
                if (!o_Tx_Active) begin
                    dv_d          = 1'b1;
                    byte_d        = acc_q;
                    acc_d         = DATA_ZERO;
                    csum_flight_d = 1'b1;
                    state_d       = ST_WAIT_DONE;
                end else begin
                    state_d = ST_CSUM;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dv_q       <= 1'b0;
            byte_q     <= DATA_ZERO;
            overflow_q <= 1'b0;
            rx_cnt_q   <= CNT_ZERO;
            tx_cnt_q   <= CNT_ZERO;
            gap_q      <= GAP_ZERO;
`ifdef ECHO_CSUM_EN
            acc_q         <= DATA_ZERO;
            csum_flight_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            dv_q       <= dv_d;
            byte_q     <= byte_d;
            overflow_q <= overflow_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            gap_q      <= gap_d;
`ifdef ECHO_CSUM_EN
            acc_q         <= acc_d;
            csum_flight_q <= csum_flight_d;
`endif
        end
    end

    assign iTx_DV    = dv_q;
    assign i_Tx_Byte = byte_q;
    assign overflow  = overflow_q;
    assign rx_cnt    = rx_cnt_q;
    assign tx_cnt    = tx_cnt_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed bench for uart_echo_fifo: one instance without gap, one with GAP_CYCLES=5.
module tb_uart_echo_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [1:0] mode = 2'd0;
    logic       tx_active = 1'b0;
    logic       tx_done = 1'b0;

    logic        dv0, dvg;
    logic [7:0]  byte0, byteg;
    logic [4:0]  cnt0, cntg;
    logic        ov0, ovg;
    logic [15:0] rxc0, rxcg, txc0, txcg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_echo_fifo #(.DATA_W(8), .DEPTH(16), .GAP_CYCLES(0), .CNT_W(16)) dut (
        .MAX10_CLK1_50(clk), .reset(reset), .Rx_valid(rx_valid), .rx_data(rx_data),
        .mode(mode), .o_Tx_Active(tx_active), .o_Tx_Done(tx_done),
        .iTx_DV(dv0), .i_Tx_Byte(byte0), .fifo_count(cnt0), .overflow(ov0),
        .rx_cnt(rxc0), .tx_cnt(txc0)
    );

    uart_echo_fifo #(.DATA_W(8), .DEPTH(16), .GAP_CYCLES(5), .CNT_W(16)) dut_gap (
        .MAX10_CLK1_50(clk), .reset(reset), .Rx_valid(rx_valid), .rx_data(rx_data),
        .mode(mode), .o_Tx_Active(tx_active), .o_Tx_Done(tx_done),
        .iTx_DV(dvg), .i_Tx_Byte(byteg), .fifo_count(cntg), .overflow(ovg),
        .rx_cnt(rxcg), .tx_cnt(txcg)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        rx_valid  = 1'b0;
        tx_done   = 1'b0;
        tx_active = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [1:0] m, input logic [7:0] d);
        rx_valid = 1'b1;
        mode     = m;
        rx_data  = d;
        tick();
        rx_valid = 1'b0;
    endtask

    // Wait (bounded) for a start pulse on the no-gap instance, check the word, answer with o_Tx_Done.
    task automatic expect_tx(input string tag, input logic [7:0] exp);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (dv0) seen = 1'b1;
            else tick();
        end
        check_eq({tag, "_dv"}, 32'(seen), 32'd1);
        if (seen) begin
            check_eq({tag, "_byte"}, 32'(byte0), 32'(exp));
            tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
    endtask

    typedef struct { logic [1:0] m; logic [7:0] d; logic [7:0] e; } vec_t;
    vec_t xf_vec [6] = '{
        '{2'd1, 8'h3C, 8'hC3}, '{2'd2, 8'h3C, 8'h3D}, '{2'd3, 8'h3C, 8'h3C},
        '{2'd2, 8'hFF, 8'h00}, '{2'd3, 8'h01, 8'h80}, '{2'd3, 8'h12, 8'h48}
    };

    initial begin
        int first_g;
        int first_0;
        int dv_seen;
        logic [7:0] gap_byte;

        // Reset state
        do_reset();
        check_eq("rst_dv", 32'(dv0), 32'd0);
        check_eq("rst_byte", 32'(byte0), 32'd0);
        check_eq("rst_count", 32'(cnt0), 32'd0);
        check_eq("rst_ovf", 32'(ov0), 32'd0);
        check_eq("rst_rxcnt", 32'(rxc0), 32'd0);
        check_eq("rst_txcnt", 32'(txc0), 32'd0);

        // Single word, latency N+2
        rx_valid = 1'b1; mode = 2'd0; rx_data = 8'h41;
        tick();
        rx_valid = 1'b0;
        check_eq("single_n1_dv", 32'(dv0), 32'd0);
        tick();
        check_eq("single_n2_dv", 32'(dv0), 32'd1);
        check_eq("single_byte", 32'(byte0), 32'h41);
        tick();
        check_eq("single_dv_pulse", 32'(dv0), 32'd0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check_eq("single_txcnt", 32'(txc0), 32'd1);
        check_eq("single_count", 32'(cnt0), 32'd0);
        check_eq("single_rxcnt", 32'(rxc0), 32'd1);

        // Transforms
        foreach (xf_vec[i]) begin
            push(xf_vec[i].m, xf_vec[i].d);
            expect_tx($sformatf("xform%0d", i), xf_vec[i].e);
        end
        tick();
        check_eq("xform_txcnt", 32'(txc0), 32'd7);

        // Burst with o_Tx_Done withheld, then drain in order
        do_reset();
        for (int w = 0; w < 18; w++) begin
            rx_valid = 1'b1; mode = 2'd0; rx_data = 8'(w);
            tick();
        end
        rx_valid = 1'b0;
        check_eq("burst_count", 32'(cnt0), 32'd16);
        check_eq("burst_ovf", 32'(ov0), 32'd1);
        check_eq("burst_rxcnt", 32'(rxc0), 32'd17);
        check_eq("burst_head_byte", 32'(byte0), 32'd0);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        for (int w = 1; w < 17; w++) begin
            expect_tx($sformatf("burst_w%0d", w), 8'(w));
`ifdef ECHO_CSUM_EN
            if (w == 10) expect_tx("burst_csum", 8'h0B);
`endif
        end
        tick();
        check_eq("burst_drained", 32'(cnt0), 32'd0);
`ifdef ECHO_CSUM_EN
        check_eq("burst_txcnt", 32'(txc0), 32'd18);
`else
        check_eq("burst_txcnt", 32'(txc0), 32'd17);
`endif
        check_eq("burst_ovf_sticky", 32'(ov0), 32'd1);

        // Reset mid-transfer with three words queued
        do_reset();
        for (int w = 0; w < 4; w++) push(2'd0, 8'hA0 + 8'(w));
        check_eq("mid_count_pre", 32'(cnt0), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_dv", 32'(dv0), 32'd0);
        check_eq("mid_byte", 32'(byte0), 32'd0);
        check_eq("mid_count", 32'(cnt0), 32'd0);
        check_eq("mid_rxcnt", 32'(rxc0), 32'd0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        dv_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (dv0) dv_seen++;
            tick();
        end
        check_eq("mid_late_done_dv", 32'(dv_seen), 32'd0);
        check_eq("mid_late_done_txcnt", 32'(txc0), 32'd0);

        // Inter-word gap: second start 6 cycles after first done (GAP=5), 2 cycles with no gap
        do_reset();
        push(2'd0, 8'h55);
        push(2'd0, 8'h66);
        check_eq("gap_first_dv", 32'(dvg), 32'd1);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        first_g = -1;
        first_0 = -1;
        gap_byte = 8'h00;
        for (int i = 1; i <= 20; i++) begin
            if (dvg && first_g < 0) begin
                first_g  = i;
                gap_byte = byteg;
            end
            if (dv0 && first_0 < 0) first_0 = i;
            tick();
        end
        check_eq("gap5_delay", 32'(first_g), 32'd6);
        check_eq("gap5_byte", 32'(gap_byte), 32'h66);
        check_eq("gap0_delay", 32'(first_0), 32'd2);

`ifdef ECHO_CSUM_EN
        // Checksum after terminator
        do_reset();
        push(2'd0, 8'h31);
        push(2'd0, 8'h32);
        push(2'd0, 8'h0A);
        expect_tx("csum_w0", 8'h31);
        expect_tx("csum_w1", 8'h32);
        expect_tx("csum_term", 8'h0A);
        expect_tx("csum_word", 8'h09);
        tick();
        check_eq("csum_txcnt", 32'(txc0), 32'd4);
        check_eq("csum_rxcnt", 32'(rxc0), 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
- Parametrised successor to the single-byte echo path between the UART receiver and transmitter.
- Buffers received words in a DEPTH-entry FIFO and optionally transforms each word.
- Re-transmits buffered words through the UART TX handshake with a configurable inter-word gap.
- Reports occupancy, a sticky overflow flag and rx/tx word counters to the board control logic (LEDs).

Parameters:
- DATA_W, 8: word width; must match the UART byte width.
- DEPTH, 16: FIFO entries; power of 2, minimum 2.
- GAP_CYCLES, 0: idle clocks after each o_Tx_Done before the next load; 0 means no gap.
- CNT_W, 16: width of the rx/tx word counters.
- TERM_CHAR, 8'h0A: terminator word; used only when ECHO_CSUM_EN is defined.

Ports:
- MAX10_CLK1_50  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- Rx_valid  in  1  one-cycle pulse; rx_data is valid.
- rx_data  in  DATA_W  received word.
- mode  in  2  transform select, sampled on Rx_valid: 0 pass, 1 bitwise invert, 2 increment mod 2^DATA_W, 3 bit-reverse.
- o_Tx_Active  in  1  UART transmitter busy.
- o_Tx_Done  in  1  one-cycle pulse; current word has been sent.
- iTx_DV  out  1  one-cycle start pulse to the UART TX.
- i_Tx_Byte  out  DATA_W  word to transmit; held stable from iTx_DV until o_Tx_Done.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; a received word was dropped.
- rx_cnt  out  CNT_W  words accepted into the FIFO; wraps.
- tx_cnt  out  CNT_W  words completed (o_Tx_Done seen in WAIT_DONE); wraps.

Behaviour:
- Reset: all outputs 0, FIFO empty, pointers 0, FSM in IDLE, gap counter 0.
- Reset asserted mid-transfer aborts the transfer; a late o_Tx_Done is ignored.
- Push:
  - Rx_valid with FIFO not full writes transform(mode, rx_data) at the clock edge ending that cycle.
  - The transform is combinational before the write.
- Full:
  - Rx_valid while full and no pop in the same cycle: word dropped, overflow set to 1, rx_cnt unchanged.
  - Push and pop in the same cycle while full: push accepted, count unchanged.
- Pointers: wrap modulo DEPTH.
- fifo_count: +1 on push-only, -1 on pop-only, unchanged on both.
- TX FSM states:
  - IDLE: if FIFO not empty and o_Tx_Active=0, latch the head into i_Tx_Byte, pulse iTx_DV for one cycle, pop, go to WAIT_DONE.
  - WAIT_DONE: wait for o_Tx_Done; then increment tx_cnt and go to GAP if GAP_CYCLES>0, else IDLE.
  - GAP: count GAP_CYCLES clocks, then IDLE.
- Latency: Rx_valid in cycle N into an empty FIFO with TX idle gives iTx_DV high in cycle N+2.
- Back-to-back: at most one iTx_DV per o_Tx_Done; iTx_DV is never asserted outside IDLE.
- Empty: IDLE holds, iTx_DV stays 0, i_Tx_Byte holds its last value.
- Counters wrap from 2^CNT_W-1 to 0.

Optional Feature:
- Macro: ECHO_CSUM_EN.
- Defined:
  - A running XOR is kept over each transformed word as it is transmitted.
  - After o_Tx_Done for a word equal to TERM_CHAR, the FSM enters state CSUM: it transmits the accumulator as one extra word (iTx_DV pulse, WAIT_DONE, GAP), then clears the accumulator.
  - The checksum covers every word since the previous terminator, terminator included.
  - The extra word increments tx_cnt but is not counted in rx_cnt or fifo_count.
  - Reset clears the accumulator.
- Undefined: no CSUM state and no accumulator; TERM_CHAR is unused.

Decomposition:
- Shared package uart_pkg:
  - Mode encodings MODE_PASS/MODE_INV/MODE_INC/MODE_REV.
  - FSM state encoding ST_IDLE/ST_WAIT_DONE/ST_GAP/ST_CSUM.
  - Default DATA_W.
- One sub-module, sync_fifo (DATA_W, DEPTH): synchronous FIFO with push, pop, full, empty and count.
- The transform function and the TX FSM stay in uart_echo_fifo.

Test Plan:
- Single word: mode=0, Rx_valid with 8'h41 at cycle N, TX idle -> iTx_DV at N+2 with i_Tx_Byte=8'h41; after o_Tx_Done, tx_cnt=1 and fifo_count=0.
- Transforms: send 8'h3C with modes 1, 2 and 3 -> transmitted words 8'hC3, 8'h3D and 8'h3C; send 8'hFF with mode=2 -> 8'h00.
- Burst and full:
  - Hold o_Tx_Done off and push DEPTH+2 words 0..17 -> fifo_count=16 (one word was popped into TX), overflow=1, rx_cnt=17.
  - Release o_Tx_Done -> words transmitted in order 0..16.
- Gap: GAP_CYCLES=5, two queued words -> the second iTx_DV comes exactly 6 cycles after the first o_Tx_Done.
- Reset mid-operation:
  - Assert reset while in WAIT_DONE with 3 words queued -> next cycle all outputs 0 and fifo_count=0.
  - A following o_Tx_Done pulse -> no iTx_DV and tx_cnt=0.
- ECHO_CSUM_EN: send 8'h31, 8'h32, 8'h0A -> transmitted 8'h31, 8'h32, 8'h0A, then 8'h09; tx_cnt=4, rx_cnt=3.
